regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-read-port register file for the pipelined MIPS core.
//   Decode reads NUM_RD operands per cycle; writeback writes one register per cycle.
//   Same-cycle write-to-read bypass removes the separate writeback-forwarding path.
//   A per-register pending bit (scoreboard) lets decode detect load-use hazards.
// PARAMETERS
//   WIDTH    32  data width of each register, in bits
//   DEPTH    32  number of registers; must be a power of 2, >= 2
//   NUM_RD   2   number of independent read ports, 1..4
//   READ_REG 0   0: combinational read; 1: read data registered, 1-cycle latency
//   ZERO_R0  1   1: register 0 is hardwired to zero; 0: register 0 is ordinary storage
//   AW       $clog2(DEPTH), derived localparam
// PORTS
//   clk        in   1           rising-edge clock
//   reset      in   1           asynchronous, active-high reset
//   rd_addr    in   NUM_RD*AW   read addresses; port i uses bits [i*AW +: AW]
//   rd_data    out  NUM_RD*WIDTH read data; port i uses bits [i*WIDTH +: WIDTH]
//   rd_busy    out  NUM_RD      pending bit of the register addressed on each read port
//   wr_en      in   1           write enable (writeback stage)
//   wr_addr    in   AW          write address, separate from all read addresses
//   wr_data    in   WIDTH       write data
//   busy_set   in   1           mark register busy_addr as pending (load issued)
//   busy_addr  in   AW          destination register of the issued load
// BEHAVIOUR
//   Reset: all registers = 0, all pending bits = 0; rd_data = 0 when READ_REG=1.
//     Reset asserted mid-operation aborts any write in that cycle.
//   Write: on posedge clk, when wr_en=1, regs[wr_addr] <= wr_data.
//     When ZERO_R0=1 and wr_addr=0, the write is dropped.
//   Read (READ_REG=0): rd_data[i] is combinational.
//     - If ZERO_R0=1 and rd_addr[i]=0: rd_data[i] = 0.
//     - Else if wr_en=1 and wr_addr=rd_addr[i]: rd_data[i] = wr_data (bypass).
//     - Else: rd_data[i] = regs[rd_addr[i]].
//   Read (READ_REG=1): the same selected value is captured at posedge clk.
//     It appears on rd_data[i] one cycle later.
//   All ports may read the same address, and may read the write address, in the same cycle.
//   Pending bits, updated at posedge clk:
//     - busy_set=1 sets pend[busy_addr].
//     - wr_en=1 clears pend[wr_addr].
//     - Same address set and cleared in one cycle: set wins (new producer).
//     - When ZERO_R0=1, register 0 is never pending.
//   rd_busy[i] = pend[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]).
//     The bypass covers the completing write. rd_busy is always combinational.
//   Width rules: no arithmetic; addresses are unsigned and compared at full AW width.
// STRUCTURE
//   Package regfile_pkg holds:
//     - default constants RF_WIDTH=32, RF_DEPTH=32, RF_NUM_RD=2;
//     - typedefs rf_addr_t and rf_data_t.
//   Sub-module regfile_read_port, instantiated NUM_RD times in a generate loop:
//     zero check, bypass compare, storage mux, optional output register, busy gating.
//   The top level owns the storage array, the write logic and the pending vector.
// TESTING
//   1. Reset, then read all 32 addresses on both ports -> every rd_data = 0, rd_busy = 0.
//   2. Write r5=0xDEADBEEF, then read r5 on port 0 and r0 on port 1 next cycle
//      -> 0xDEADBEEF and 0.
//   3. Write r0=0x1234 -> a later read of r0 returns 0 (ZERO_R0=1).
//   4. wr_en r7=0xA5A5A5A5 while both ports read r7 in the same cycle
//      -> both rd_data = 0xA5A5A5A5 (READ_REG=0).
//   5. busy_set r9; next cycle rd_busy=1; then wr_en r9=0x55 -> rd_busy=0 that cycle.
//      Then busy_set r9 with wr_en r9 in the same cycle -> r9 still pending.
//   6. READ_REG=1, NUM_RD=3: write r3=0x77, then read r3 on all ports
//      -> 0x77 appears exactly one cycle later.
//      Assert reset mid-stream -> rd_data = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and types for the multi-port register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;
  localparam int RF_AW     = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]    rf_addr_t;
  typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One read port: r0 zeroing, write bypass, storage mux,
//                optional output register and pending-bit gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int READ_REG = 0,
  parameter int ZERO_R0  = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0] pend,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_busy
);

  logic             wr_hit;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Select the operand: hardwired zero, then the completing write, then storage
  always_comb begin
    wr_hit    = wr_en && (wr_addr == rd_addr);
    rd_data_d = regs[rd_addr];
    if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
      rd_data_d = '0;
    end else if (wr_hit) begin
      rd_data_d = wr_data;
    end
  end

  // Optional pipeline register on the read data; async reset clears it at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = (READ_REG != 0) ? rd_data_q : rd_data_d;

  // A write completing this cycle satisfies the pending load, so it hides the bit
  assign rd_busy = pend[rd_addr] & ~wr_hit;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised register file with NUM_RD read ports, one write
//                port, same-cycle bypass and a load-use pending scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int READ_REG = 0,
  parameter int ZERO_R0  = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next storage contents: one write per cycle, r0 writes dropped when hardwired
  always_comb begin
    regs_d = regs_q;
    if (wr_en && !((ZERO_R0 != 0) && (wr_addr == '0))) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Next pending vector: writeback clears, a new load sets (set wins on a tie)
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (busy_set) begin
      pend_d[busy_addr] = 1'b1;
    end
    if (ZERO_R0 != 0) begin
      pend_d[0] = 1'b0;
    end
  end

  // Storage and scoreboard state; reset aborts any write in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
      regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .READ_REG (READ_REG),
        .ZERO_R0  (ZERO_R0),
        .AW       (AW)
      ) u_rd_port (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr[i*AW +: AW]),
        .regs     (regs_q),
        .pend     (pend_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data[i*WIDTH +: WIDTH]),
        .rd_busy  (rd_busy[i])
      );
    end : g_rd_port
  endgenerate

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Instance A is the
//                combinational 2-port build, instance B the registered
//                3-port build; both are compared against array models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_RD=2, READ_REG=0
  logic        a_rst;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_busy_set;
  logic [4:0]  a_busy_addr;

  // Instance B: NUM_RD=3, READ_REG=1
  logic        b_rst;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_busy_set;
  logic [4:0]  b_busy_addr;

  regfile_mp #(
    .WIDTH(32), .DEPTH(32), .NUM_RD(2), .READ_REG(0), .ZERO_R0(1)
  ) u_a (
    .clk(clk), .reset(a_rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .busy_set(a_busy_set), .busy_addr(a_busy_addr)
  );

  regfile_mp #(
    .WIDTH(32), .DEPTH(32), .NUM_RD(3), .READ_REG(1), .ZERO_R0(1)
  ) u_b (
    .clk(clk), .reset(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy_set(b_busy_set), .busy_addr(b_busy_addr)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: register contents and pending flags per instance
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          pa [32];
  bit          pb [32];
  logic [31:0] bcap [3];

  function automatic logic [31:0] exp_a(input logic [4:0] ad);
    if (ad == 5'd0) return 32'h0;
    if (a_wr_en && a_wr_addr == ad) return a_wr_data;
    return ma[ad];
  endfunction

  function automatic logic exp_a_busy(input logic [4:0] ad);
    return pa[ad] && !(a_wr_en && a_wr_addr == ad);
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] ad);
    if (ad == 5'd0) return 32'h0;
    if (b_wr_en && b_wr_addr == ad) return b_wr_data;
    return mb[ad];
  endfunction

  function automatic logic exp_b_busy(input logic [4:0] ad);
    return pb[ad] && !(b_wr_en && b_wr_addr == ad);
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic clear_a();
    for (int k = 0; k < 32; k++) begin ma[k] = 32'h0; pa[k] = 1'b0; end
  endtask

  task automatic clear_b();
    for (int k = 0; k < 32; k++) begin mb[k] = 32'h0; pb[k] = 1'b0; end
    for (int k = 0; k < 3; k++) bcap[k] = 32'h0;
  endtask

  task automatic idle_inputs();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_busy_set = 1'b0; a_busy_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_busy_set = 1'b0; b_busy_addr = '0;
  endtask

  // One clock: latch B's expected captures, apply the edge to both models
  task automatic tick();
    for (int i = 0; i < 3; i++) bcap[i] = exp_b(b_rd_addr[i*5 +: 5]);
    @(posedge clk);
    if (a_rst) clear_a();
    else begin
      if (a_wr_en && a_wr_addr != 0) ma[a_wr_addr] = a_wr_data;
      if (a_wr_en) pa[a_wr_addr] = 1'b0;
      if (a_busy_set && a_busy_addr != 0) pa[a_busy_addr] = 1'b1;
    end
    if (b_rst) clear_b();
    else begin
      if (b_wr_en && b_wr_addr != 0) mb[b_wr_addr] = b_wr_data;
      if (b_wr_en) pb[b_wr_addr] = 1'b0;
      if (b_busy_set && b_busy_addr != 0) pb[b_busy_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    a_rd_addr = '0; b_rd_addr = '0;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_a(); clear_b();
    #1;
    checks++;
    if (b_rd_data !== 96'h0) begin
      errors++; $display("FAIL reset_b_data got=%h exp=0", b_rd_data);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    for (int ad = 0; ad < 32; ad++) begin
      a_rd_addr = {5'(ad), 5'(ad)};
      #1;
      checks++;
      if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read addr=%0d got data=%h busy=%b exp 0/00", ad, a_rd_data, a_rd_busy);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    tick();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_p0 got=%h exp=deadbeef", a_rd_data[31:0]);
    end
    checks++;
    if (a_rd_data[63:32] !== 32'h0) begin
      errors++; $display("FAIL write_read_p1_r0 got=%h exp=0", a_rd_data[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234;
    tick();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (a_rd_data !== 64'h0) begin
      errors++; $display("FAIL zero_r0 got=%h exp=0", a_rd_data);
    end
  endtask

  task automatic test_bypass();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5;
    a_rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (a_rd_data !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL bypass got=%h exp=a5a5a5a5a5a5a5a5", a_rd_data);
    end
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic test_busy();
    a_busy_set = 1'b1; a_busy_addr = 5'd9;
    tick();
    a_busy_set = 1'b0;
    a_rd_addr = {5'd9, 5'd9};
    #1;
    checks++;
    if (a_rd_busy !== 2'b11) begin
      errors++; $display("FAIL busy_set got=%b exp=11", a_rd_busy);
    end
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
    #1;
    checks++;
    if (a_rd_busy !== 2'b00 || a_rd_data !== {32'h55, 32'h55}) begin
      errors++; $display("FAIL busy_clear_bypass got busy=%b data=%h exp 00/55", a_rd_busy, a_rd_data);
    end
    tick();
    a_busy_set = 1'b1; a_busy_addr = 5'd9;
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h66;
    tick();
    a_busy_set = 1'b0; a_wr_en = 1'b0;
    #1;
    checks++;
    if (a_rd_busy !== 2'b11) begin
      errors++; $display("FAIL busy_set_wins got=%b exp=11", a_rd_busy);
    end
    a_busy_set = 1'b1; a_busy_addr = 5'd0;
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h77;
    tick();
    a_busy_set = 1'b0; a_wr_en = 1'b0;
    a_rd_addr = {5'd9, 5'd0};
    #1;
    checks++;
    if (a_rd_busy !== 2'b00) begin
      errors++; $display("FAIL busy_r0_never got=%b exp=00", a_rd_busy);
    end
  endtask

  task automatic test_random_a();
    for (int n = 0; n < 300; n++) begin
      a_wr_en     = 1'($urandom_range(0, 1));
      a_wr_addr   = rnd_addr();
      a_wr_data   = $urandom;
      a_busy_set  = ($urandom_range(0, 2) == 0);
      a_busy_addr = rnd_addr();
      a_rd_addr   = {rnd_addr(), rnd_addr()};
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (a_rd_data[i*32 +: 32] !== exp_a(a_rd_addr[i*5 +: 5]) ||
            a_rd_busy[i] !== exp_a_busy(a_rd_addr[i*5 +: 5])) begin
          errors++;
          $display("FAIL rand_a n=%0d port=%0d got data=%h busy=%b exp data=%h busy=%b",
                   n, i, a_rd_data[i*32 +: 32], a_rd_busy[i],
                   exp_a(a_rd_addr[i*5 +: 5]), exp_a_busy(a_rd_addr[i*5 +: 5]));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_regread_b();
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h77;
    b_rd_addr = {5'd4, 5'd4, 5'd4};
    tick();
    b_wr_en = 1'b0;
    b_rd_addr = {5'd3, 5'd3, 5'd3};
    #1;
    checks++;
    if (b_rd_data !== 96'h0) begin
      errors++; $display("FAIL regread_early got=%h exp=0", b_rd_data);
    end
    tick();
    checks++;
    if (b_rd_data !== {32'h77, 32'h77, 32'h77}) begin
      errors++; $display("FAIL regread_latency got=%h exp=77 on all ports", b_rd_data);
    end
  endtask

  task automatic test_random_b();
    for (int n = 0; n < 300; n++) begin
      b_wr_en     = 1'($urandom_range(0, 1));
      b_wr_addr   = rnd_addr();
      b_wr_data   = $urandom;
      b_busy_set  = ($urandom_range(0, 2) == 0);
      b_busy_addr = rnd_addr();
      b_rd_addr   = {rnd_addr(), rnd_addr(), rnd_addr()};
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (b_rd_busy[i] !== exp_b_busy(b_rd_addr[i*5 +: 5])) begin
          errors++;
          $display("FAIL rand_b_busy n=%0d port=%0d got=%b exp=%b",
                   n, i, b_rd_busy[i], exp_b_busy(b_rd_addr[i*5 +: 5]));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (b_rd_data[i*32 +: 32] !== bcap[i]) begin
          errors++;
          $display("FAIL rand_b_data n=%0d port=%0d got=%h exp=%h",
                   n, i, b_rd_data[i*32 +: 32], bcap[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h77;
    tick();
    b_wr_en = 1'b0;
    b_rd_addr = {5'd3, 5'd3, 5'd3};
    tick();
    checks++;
    if (b_rd_data !== {32'h77, 32'h77, 32'h77}) begin
      errors++; $display("FAIL midrst_pre got=%h exp=77 on all ports", b_rd_data);
    end
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h99;
    #2;
    b_rst = 1'b1;
    #1;
    checks++;
    if (b_rd_data !== 96'h0) begin
      errors++; $display("FAIL midrst_async got=%h exp=0", b_rd_data);
    end
    @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    b_wr_en = 1'b0;
    clear_b();
    tick();
    checks++;
    if (b_rd_data !== 96'h0) begin
      errors++; $display("FAIL midrst_write_aborted got=%h exp=0", b_rd_data);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_rd_addr = '0; b_rd_addr = '0;
    idle_inputs();
    clear_a(); clear_b();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_busy();
    test_random_a();
    test_regread_b();
    test_random_b();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
